// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one full-adder cell plus a carry
// flop. Operands latch on an accepted start; {cout,sum} are valid WIDTH+1
// edges later, flagged by a one-cycle done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (cout = 1 means no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [WIDTH-1:0] w_res_nxt, w_b_load;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             w_accept, w_last, w_s, w_c, w_c_load;

  // Subtraction is a + ~b + 1, so only the captured b and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  // Full-adder cell on the current LSBs and the carry flop
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB result
  always_comb begin
    w_res_nxt            = r_res >> 1;
    w_res_nxt[WIDTH-1]   = w_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; DONE also accepts a new start
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shifters, carry, counter and result; sum/cout move only on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= w_b_load;
      r_c   <= w_c_load;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= w_res_nxt;
        cout <= w_c;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder and the sequential successor to the single-bit full adder cell. It latches two WIDTH-bit operands plus a carry-in on a start request, then adds one bit per clock, LSB first, through one full-adder cell and a carry flip-flop. It reports completion with a one-cycle done pulse. It serves as the small-area adder for multi-cycle datapaths in the challenge series.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a new addition; sampled only when busy=0
a  input  WIDTH  operand A; captured on the accepted start
b  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  registered final carry-out

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, the state goes to IDLE and busy=0, done=0, sum=0, cout=0. The internal operand registers, carry flip-flop and bit counter are cleared.
- Reset mid-operation aborts the addition. No done pulse is issued for it. sum/cout read 0.
- State IDLE: busy=0. If start=1, the block captures a, b and cin into shift registers, loads carry flop = cin and bit counter = 0, and goes to RUN.
- State RUN: busy=1. On each edge:
  - s = a_sh[0] ^ b_sh[0] ^ c
  - c <= majority(a_sh[0], b_sh[0], c)
  - a_sh and b_sh shift right by 1
  - s is shifted into the MSB of the internal result register
  - bit counter increments
- When the counter reaches WIDTH-1 on that edge, the state goes to DONE. sum and cout are loaded from the final result register and carry on that same edge.
- State DONE: one cycle. done=1, busy=0. The next state is IDLE, or RUN if start=1; the DONE cycle accepts a new start so back-to-back operation is possible.
- Latency: start sampled at edge E0. Bits are processed at edges E1..E_WIDTH. done is high during the cycle after E_WIDTH. Total is WIDTH+1 edges from accepted start to done.
- Throughput: one result per WIDTH+1 cycles when start is held high.
- start while busy=1 is ignored. Operands captured earlier are unaffected, and input changes during RUN have no effect.
- sum and cout change only on a completion edge or on reset. They stay stable throughout RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), with no truncation of the carry.
- WIDTH=1 case: RUN lasts exactly one edge and the result equals the full-adder truth table.
- Bit counter width is $clog2(WIDTH) with a minimum of 1 bit.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: an extra input port sub (1 bit) is captured with the operands on the accepted start. When sub=1:
  - b is inverted bit-wise as it is captured, and the carry flop loads 1 (cin is ignored).
  - Result: sum = a - b mod 2^WIDTH.
  - cout = 1 means no borrow (a >= b unsigned); cout = 0 means borrow.
  - Latency and handshake are unchanged.
- Undefined: the sub port does not exist and the block is add-only.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start for 1 cycle -> busy high for 8 cycles; done pulses exactly 9 edges after start; sum=8'h10, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start re-asserted with a=8'h55 during RUN of 8'h0F+8'h01 -> ignored; result 8'h10. Holding start high through DONE launches the next op with no idle cycle.
- rst_n=0 for one edge at the 4th RUN cycle -> busy=0, done never pulses, sum=0, cout=0. A fresh start afterwards computes correctly.
- WIDTH=3: exhaustive sweep of all 128 {a,b,cin} combinations -> every {cout,sum} equals a+b+cin. The bench prints $time, operands and result.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1 with a=8'h05, b=8'h07 -> sum=8'hFE, cout=0. sub=1 with a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
